trace_capture: RTL

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/trace_capture.sv | 107 ++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and defaults for the trace capture block
// Purpose: state encoding, trace entry layout and default sizing used by
//          trace_capture and trace_fifo.
// Contents: DEFAULT_DEPTH, DEFAULT_MAX_CYCLES, state_t + ST_* codes,
//           trace_entry_t {idx[15:0], pc[31:0], inst[31:0]} (80 bits).
package trace_pkg;

   localparam int DEFAULT_DEPTH      = 16;
   localparam int DEFAULT_MAX_CYCLES = 2048;

   // Capture FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CAPTURE = 2'd1;
   localparam state_t ST_DRAIN   = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   typedef struct packed {
      logic [15:0] idx;
      logic [31:0] pc;
      logic [31:0] inst;
   } trace_entry_t;

   localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through trace FIFO
// Purpose: holds captured trace entries; head entry is always visible.
// Ports: clk_in, reset (sync, active-high), flush (sync clear),
//        push/push_data (write request), pop (read request),
//        head (entry at read pointer, zero when empty), empty, full, count.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk_in,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [ENTRY_W-1:0]         push_data,
   input  logic                       pop,
   output logic [ENTRY_W-1:0]         head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   // Zero the head when empty so the outputs are clean out of reset
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointers are AW bits wide, so they wrap modulo DEPTH for free
   always_ff @(posedge clk_in) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - CPU pc/inst trace capture with FWFT output stream
// Purpose: on start, samples {cycle index, pc, inst} every cycle into a FIFO
//          until MAX_CYCLES samples or stop, then drains and reports done.
// Ports: clk_in, reset (sync, active-high), start, stop, pc, inst,
//        out_valid/out_ready/out_idx/out_pc/out_inst (trace word stream),
//        busy (CAPTURE or DRAIN), done (DONE), overflow (sticky drop flag).
module trace_capture
   import trace_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_idx,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        busy,
   output logic        done,
   output logic        overflow
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [15:0] LAST_IDX = 16'(MAX_CYCLES - 1);

   state_t          state;
   logic [15:0]     cycle_cnt;
   logic            launch;
   logic            capturing;
   logic            pop;
   logic            drop;
   logic            drain_last;
   logic            full;
   logic            empty;
   logic [AW:0]     count;
   logic [ENTRY_W-1:0] head;
   trace_entry_t    head_e;
   trace_entry_t    sample;

   assign launch    = start && (state == ST_IDLE || state == ST_DONE);
   assign capturing = (state == ST_CAPTURE);
   assign pop       = out_valid && out_ready;
   // A full FIFO loses the sample only when nothing leaves this cycle
   assign drop      = capturing && full && !pop;
   // FIFO is empty after this edge: already empty, or its last entry leaves now
   assign drain_last = empty || (count == {{AW{1'b0}}, 1'b1} && pop);

   assign sample = '{idx: cycle_cnt, pc: pc, inst: inst};
   assign head_e = head;

   assign out_valid = !empty;
   assign out_idx   = head_e.idx;
   assign out_pc    = head_e.pc;
   assign out_inst  = head_e.inst;
   assign busy      = (state == ST_CAPTURE) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .reset     (reset),
      .flush     (launch),
      .push      (capturing),
      .push_data (sample),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full),
      .count     (count)
   );

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state     <= ST_IDLE;
         cycle_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_CAPTURE;
                  cycle_cnt <= '0;
                  overflow  <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               // Counter advances even on dropped samples so gaps show in idx
               if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
               if (drop) overflow <= 1'b1;
               if (stop || cycle_cnt == LAST_IDX) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_last) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
